// File: rtl/card7seg_bank.sv
// card7seg_bank: bank of card-display slots, each decoding a stored card
// code onto an active-low seven-segment digit. A newly loaded slot shows
// a dash for REVEAL_CYCLES cycles before its card appears.
module card7seg_bank #(
  parameter int NUM_SLOTS     = 6,
  parameter int REVEAL_CYCLES = 4
) (
  input  logic                   slow_clock,
  input  logic                   reset,
  input  logic                   clear_all,
  input  logic                   load_valid,
  input  logic [3:0]             load_slot,
  input  logic [3:0]             load_card,
  output logic                   load_ready,
  output logic                   load_err,
  output logic [NUM_SLOTS-1:0]   occupied,
  output logic [7*NUM_SLOTS-1:0] seg7
);

  localparam int             CW        = $clog2(REVEAL_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_LOAD  = CW'(REVEAL_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [4:0]     SLOT_LIM  = 5'(NUM_SLOTS);
  localparam logic [6:0]     SEG_DASH  = 7'b0111111;
  localparam logic [6:0]     SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE   = 1'b0,
    REVEAL = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic [3:0]    reveal_slot;
  logic [3:0]    cards [NUM_SLOTS];
  logic          accept;
  logic          slot_ok;
  logic          load_go;
  logic          show_dash;

  // Card code to active-low {g,f,e,d,c,b,a}; codes outside 1..13 are blank.
  function automatic logic [6:0] card_seg(input logic [3:0] card);
    logic [6:0] seg;
    case (card)
      4'd1:    seg = 7'b0001000;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      4'd10:   seg = 7'b1000000;
      4'd11:   seg = 7'b1100001;
      4'd12:   seg = 7'b0011000;
      4'd13:   seg = 7'b0001001;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // True when the code names a real card.
  function automatic logic is_card(input logic [3:0] card);
    return (card >= 4'd1) && (card <= 4'd13);
  endfunction

  // Load handshake: clear_all takes priority and silently drops a load.
  always_comb begin
    slot_ok = ({1'b0, load_slot} < SLOT_LIM);
    accept  = load_valid && load_ready && !clear_all;
    load_go = accept && slot_ok;
  end

  // FSM state register.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load_go) begin
          state_next = REVEAL;
        end else begin
          state_next = IDLE;
        end
      end
      REVEAL: begin
        if (clear_all || (count == '0)) begin
          state_next = IDLE;
        end else begin
          state_next = REVEAL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: ready only when idle, dash only while revealing.
  always_comb begin
    load_ready = 1'b0;
    show_dash  = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        show_dash  = 1'b0;
      end
      REVEAL: begin
        load_ready = 1'b0;
        show_dash  = 1'b1;
      end
      default: begin
        load_ready = 1'b0;
        show_dash  = 1'b0;
      end
    endcase
  end

  // Reveal counter and latched slot index.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      count       <= '0;
      reveal_slot <= 4'd0;
    end else if (clear_all) begin
      count       <= '0;
      reveal_slot <= 4'd0;
    end else if (load_go) begin
      count       <= CNT_LOAD;
      reveal_slot <= load_slot;
    end else if ((state == REVEAL) && (count != '0)) begin
      count       <= count - CNT_ONE;
      reveal_slot <= reveal_slot;
    end else begin
      count       <= count;
      reveal_slot <= reveal_slot;
    end
  end

  // Bad-slot error flag, high for the single cycle after the rejected load.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      load_err <= 1'b0;
    end else begin
      load_err <= accept && !slot_ok;
    end
  end

  // Slot card registers and their occupied flags, written together.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cards[i]    <= 4'd0;
        occupied[i] <= 1'b0;
      end
    end else if (clear_all) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cards[i]    <= 4'd0;
        occupied[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (load_go && (load_slot == 4'(i))) begin
          cards[i]    <= load_card;
          occupied[i] <= is_card(load_card);
        end else begin
          cards[i]    <= cards[i];
          occupied[i] <= occupied[i];
        end
      end
    end
  end

  // Digit drive: dash on the revealing slot, decoded card everywhere else.
  always_comb begin
    seg7 = '1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (show_dash && (reveal_slot == 4'(i))) begin
        seg7[7*i +: 7] = SEG_DASH;
      end else begin
        seg7[7*i +: 7] = card_seg(cards[i]);
      end
    end
  end

endmodule
